pmem_arbiter: RTL
=================

Name: pmem_arbiter

Overview:
- Arbitrates line-sized (256-bit) requests from the instruction cache and the data cache onto the single physical memory port (pmem_*).
- Sits directly upstream of physical memory, between the two caches and the pmem interface.
- Registers each granted request and holds it stable until pmem_resp.
- Returns read data and a single-cycle response to the granted cache; unserved caches wait.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line / pmem data width
OFFSET_W, 5, line offset bits forced to zero on pmem_address (log2(LINE_W/8))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  icache line read request, held until i_resp
i_address  in  ADDR_W  icache line address
i_rdata  out  LINE_W  line returned to icache
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line read request, held until d_resp
d_write  in  1  dcache line writeback request, held until d_resp
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  dcache writeback line
d_rdata  out  LINE_W  line returned to dcache
d_resp  out  1  one-cycle completion pulse to dcache
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_W  memory line address, low OFFSET_W bits zero
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion
pm_error  in  1  memory error indication
arb_error  out  1  sticky protocol/memory error flag

Behaviour:
- States: IDLE, I_XFER, D_XFER, RESP.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including the data buses.
  - The round-robin pointer is set so the icache wins the first tie.
  - arb_error clears.
  - Reset mid-transfer drops the strobes immediately. No response is generated.
- IDLE:
  - Requests are sampled each rising edge.
  - Only icache requesting -> I_XFER.
  - Only dcache (d_read|d_write) requesting -> D_XFER.
  - Both requesting -> grant goes to the client not granted most recently (round-robin); the pointer updates on every grant.
  - On grant, the address (low OFFSET_W bits zeroed) is latched into pmem_address.
  - A dcache write also latches d_wdata into pmem_wdata.
  - The strobe asserts the cycle after the request is first seen; it is registered, not combinational.
- I_XFER / D_XFER:
  - pmem_read (or pmem_write) and pmem_address/pmem_wdata are held constant until pmem_resp=1.
  - Input changes from either cache are ignored.
  - On the pmem_resp edge:
    - Strobes deassert on that edge.
    - For reads, pmem_rdata is captured into the granted client's rdata register.
    - State goes to RESP.
- RESP:
  - Exactly one cycle, with i_resp or d_resp = 1 for the granted client only.
  - rdata stays valid in that cycle and is held thereafter until the next fill for that client.
  - Requests are not sampled in this cycle; clients drop the request in the same cycle they see resp.
  - Next state is IDLE.
- Latency:
  - Request first seen at edge k -> strobe high after edge k.
  - pmem_resp seen at edge m -> resp high after edge m for one cycle -> IDLE after edge m+1.
  - The earliest next grant is at edge m+2.
- d_read and d_write both high: the write is serviced and arb_error sets.
- pm_error=1 during a transfer sets arb_error; the transfer still completes on pmem_resp.
- pmem_read and pmem_write are never high together. Neither is high outside the XFER states.
- arb_error is sticky until reset.

Test Plan:
- Icache only: i_read=1, i_address=32'h0000_0064, memory returns line A after 10 cycles -> pmem_address=32'h0000_0060, pmem_read held 10 cycles, i_rdata=A with a single i_resp pulse, d_resp stays 0.
- Dcache writeback: d_write=1, d_address=32'h0000_1000, d_wdata=B -> pmem_write=1, pmem_wdata=B held until pmem_resp, then d_resp for exactly one cycle.
- Simultaneous requests after reset: i_read and d_read asserted together -> icache granted first, dcache next, with 1 idle cycle between. A second simultaneous pair -> dcache granted first.
- Reset mid-transfer: rst_n low while in D_XFER -> pmem_write drops without waiting for a clock, no d_resp appears, and the first post-reset request is granted normally.
- Protocol errors: d_read=d_write=1 -> a write is issued and arb_error=1; separately, pm_error pulse during a read -> arb_error=1, the read still completes, and arb_error stays high until rst_n.

Source files
------------

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmem_arbiter : round-robin icache/dcache arbiter onto one line-wide pmem port
// rev 1.0
// ----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              pm_error,
  output logic              arb_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_XFER = 2'd1,
    S_D_XFER = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [OFFSET_W-1:0] C_OFFSET_ZERO = '0;

  state_t            state_q;
  logic              last_d_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic              arb_error_q;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_d;
  logic              w_unused_offset_bits;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  // On a tie the client not granted last time wins; last_d_q resets high so icache wins first.
  assign w_grant_d = w_d_req & (~w_i_req | ~last_d_q);

  assign w_unused_offset_bits = ^{i_address[OFFSET_W-1:0], d_address[OFFSET_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_d_q       <= 1'b1;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      arb_error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_i_req || w_d_req) begin
            last_d_q <= w_grant_d;
            if (w_grant_d) begin
              state_q        <= S_D_XFER;
              pmem_address_q <= {d_address[ADDR_W-1:OFFSET_W], C_OFFSET_ZERO};
              pmem_write_q   <= d_write;
              pmem_read_q    <= ~d_write;
              if (d_write) begin
                pmem_wdata_q <= d_wdata;
              end
              // Conflicting dcache strobes: the writeback wins and the conflict is flagged.
              if (d_read && d_write) begin
                arb_error_q <= 1'b1;
              end
            end else begin
              state_q        <= S_I_XFER;
              pmem_address_q <= {i_address[ADDR_W-1:OFFSET_W], C_OFFSET_ZERO};
              pmem_read_q    <= 1'b1;
            end
          end
        end

        S_I_XFER, S_D_XFER: begin
          if (pm_error) begin
            arb_error_q <= 1'b1;
          end
          if (pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= S_RESP;
            if (state_q == S_I_XFER) begin
              i_rdata_q <= pmem_rdata;
              i_resp_q  <= 1'b1;
            end else begin
              if (pmem_read_q) begin
                d_rdata_q <= pmem_rdata;
              end
              d_resp_q <= 1'b1;
            end
          end
        end

        S_RESP: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i_rdata      = i_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_rdata      = d_rdata_q;
  assign d_resp       = d_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign arb_error    = arb_error_q;

  a_strobes_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(pmem_read_q && pmem_write_q)
  );

endmodule
`default_nettype wire
